// File: rtl/video_pkg.sv
// video_pkg: shared 640x480@60 timing defaults, sync polarity and color type
package video_pkg;
  localparam int H_VISIBLE_D = 640;
  localparam int H_FRONT_D   = 16;
  localparam int H_SYNC_D    = 96;
  localparam int H_BACK_D    = 48;
  localparam int V_VISIBLE_D = 480;
  localparam int V_FRONT_D   = 10;
  localparam int V_SYNC_D    = 2;
  localparam int V_BACK_D    = 33;
  localparam int H_TOTAL_D   = H_VISIBLE_D + H_FRONT_D + H_SYNC_D + H_BACK_D;
  localparam int V_TOTAL_D   = V_VISIBLE_D + V_FRONT_D + V_SYNC_D + V_BACK_D;
  localparam logic SYNC_POL  = 1'b0;
  typedef logic [23:0] color_t;
  localparam color_t BLACK   = 24'h000000;
endpackage

// File: rtl/video_axis_counter.sv
// video_axis_counter: one raster axis (horizontal or vertical) counter with window flags
//   clk, rst    clock, synchronous active-high reset
//   i_tick      advance the count this cycle
//   o_count     registered count, 0..TOTAL-1
//   o_next      value o_count takes on the next edge (before reset)
//   o_wrap      i_tick while at TOTAL-1; chains into the next axis
//   o_visible   o_next lies in the visible region
//   o_sync      o_count lies in [SYNC_START, SYNC_END)
module video_axis_counter
  import video_pkg::*;
#(
  parameter int TOTAL      = H_TOTAL_D,
  parameter int VISIBLE    = H_VISIBLE_D,
  parameter int SYNC_START = H_VISIBLE_D + H_FRONT_D,
  parameter int SYNC_END   = H_VISIBLE_D + H_FRONT_D + H_SYNC_D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  output logic [9:0] o_count,
  output logic [9:0] o_next,
  output logic       o_wrap,
  output logic       o_visible,
  output logic       o_sync
);
  logic [9:0] r_count;
  assign o_count   = r_count;
  assign o_wrap    = i_tick && r_count == 10'(TOTAL - 1);
  assign o_next    = o_wrap ? 10'd0 : r_count + 10'(i_tick);
  assign o_visible = o_next < 10'(VISIBLE);
  assign o_sync    = r_count >= 10'(SYNC_START) && r_count < 10'(SYNC_END);
  always_ff @(posedge clk)
    r_count <= rst ? 10'd0 : o_next;
endmodule

// File: rtl/vga_timing.sv
// vga_timing: 640x480@60 raster timing with a registered, sync-aligned pixel output stage
//   clk_25mhz, reset          pixel clock, synchronous active-high reset
//   x, y, active, vblank_start stage 0 raster position, visibility, frame pulse at (0,V_VISIBLE)
//   color                     pixel generator response to x/y
//   rgb, hsync, vsync, de     stage 1 outputs aligned to the same pixel
module vga_timing
  import video_pkg::*;
#(
  parameter int   H_VISIBLE   = H_VISIBLE_D,
  parameter int   H_FRONT     = H_FRONT_D,
  parameter int   H_SYNC      = H_SYNC_D,
  parameter int   H_BACK      = H_BACK_D,
  parameter int   V_VISIBLE   = V_VISIBLE_D,
  parameter int   V_FRONT     = V_FRONT_D,
  parameter int   V_SYNC      = V_SYNC_D,
  parameter int   V_BACK      = V_BACK_D,
  parameter logic SYNC_ACTIVE = SYNC_POL
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       vblank_start,
  input  color_t     color,
  output color_t     rgb,
  output logic       hsync,
  output logic       vsync,
  output logic       de
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  logic       r_run, r_active, r_vblank, r_de, r_hsync, r_vsync;
  color_t     r_rgb;
  logic [9:0] w_x_next, w_y_next;
  logic       w_h_wrap, w_h_vis, w_v_vis, w_h_sync, w_v_sync, w_unused_v_wrap;
  // r_run holds the counters at (0,0) for the first edge after reset so that
  // the first post-reset cycle presents pixel (0,0) with active high.
  video_axis_counter #(
    .TOTAL(H_TOTAL), .VISIBLE(H_VISIBLE),
    .SYNC_START(H_VISIBLE + H_FRONT), .SYNC_END(H_VISIBLE + H_FRONT + H_SYNC)
  ) u_h (
    .clk(clk_25mhz), .rst(reset), .i_tick(r_run),
    .o_count(x), .o_next(w_x_next), .o_wrap(w_h_wrap),
    .o_visible(w_h_vis), .o_sync(w_h_sync)
  );
  video_axis_counter #(
    .TOTAL(V_TOTAL), .VISIBLE(V_VISIBLE),
    .SYNC_START(V_VISIBLE + V_FRONT), .SYNC_END(V_VISIBLE + V_FRONT + V_SYNC)
  ) u_v (
    .clk(clk_25mhz), .rst(reset), .i_tick(w_h_wrap),
    .o_count(y), .o_next(w_y_next), .o_wrap(w_unused_v_wrap),
    .o_visible(w_v_vis), .o_sync(w_v_sync)
  );
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      r_run    <= 1'b0;
      r_active <= 1'b0;
      r_vblank <= 1'b0;
      r_de     <= 1'b0;
      r_rgb    <= BLACK;
      r_hsync  <= ~SYNC_ACTIVE;
      r_vsync  <= ~SYNC_ACTIVE;
    end else begin
      r_run    <= 1'b1;
      r_active <= w_h_vis && w_v_vis;
      r_vblank <= w_x_next == 10'd0 && w_y_next == 10'(V_VISIBLE);
      r_de     <= r_active;
      r_rgb    <= r_active ? color : BLACK;
      r_hsync  <= w_h_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_vsync  <= w_v_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end
  assign active       = r_active;
  assign vblank_start = r_vblank;
  assign de           = r_de;
  assign rgb          = r_rgb;
  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: checks vga_timing (default and shortened-frame instances) against a raster model
module tb_vga_timing;
  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        act;
    logic        vb;
    logic        de;
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
  } obs_t;
  typedef struct {
    bit          r;
    logic [23:0] c;
    obs_t        e;
  } vec_t;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        reset;
  logic [23:0] color;
  logic [9:0]  x_d, y_d, x_s, y_s;
  logic        act_d, vb_d, de_d, hs_d, vs_d, act_s, vb_s, de_s, hs_s, vs_s;
  logic [23:0] rgb_d, rgb_s;
  obs_t        got [2];

  vga_timing dut_d (
    .clk_25mhz(clk), .reset(reset), .x(x_d), .y(y_d), .active(act_d),
    .vblank_start(vb_d), .color(color), .rgb(rgb_d), .hsync(hs_d),
    .vsync(vs_d), .de(de_d)
  );
  vga_timing #(.V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(4)) dut_s (
    .clk_25mhz(clk), .reset(reset), .x(x_s), .y(y_s), .active(act_s),
    .vblank_start(vb_s), .color(color), .rgb(rgb_s), .hsync(hs_s),
    .vsync(vs_s), .de(de_s)
  );
  assign got[0] = {x_d, y_d, act_d, vb_d, de_d, rgb_d, hs_d, vs_d};
  assign got[1] = {x_s, y_s, act_s, vb_s, de_s, rgb_s, hs_s, vs_s};

  int   vvis [2] = '{480, 12};
  int   vfr  [2] = '{10, 2};
  int   vsy  [2] = '{2, 2};
  int   vbk  [2] = '{33, 4};
  int   t = -1;
  int   cyc = 0;
  int   last_vb [2] = '{-1, -1};
  obs_t prev [2];
  int   vectors = 0;
  int   miscompares = 0;
  vec_t tab [6];

  function automatic obs_t mk(int xx, int yy, bit a, bit v, bit d, logic [23:0] c, bit h, bit s);
    obs_t o;
    o = {10'(xx), 10'(yy), a, v, d, c, h, s};
    return o;
  endfunction

  // Raster position after tt counting edges since reset release (tt<0: in reset).
  function automatic obs_t stage0(int tt, int i);
    obs_t o = '0;
    if (tt >= 0) begin
      int p, px, py;
      p  = tt % (800 * (vvis[i] + vfr[i] + vsy[i] + vbk[i]));
      px = p % 800;
      py = p / 800;
      o.x   = 10'(px);
      o.y   = 10'(py);
      o.act = px < 640 && py < vvis[i];
      o.vb  = px == 0 && py == vvis[i];
    end
    return o;
  endfunction

  task automatic check(string nm, obs_t g, obs_t e);
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got x=%0d y=%0d act=%b vb=%b de=%b rgb=%h hs=%b vs=%b want x=%0d y=%0d act=%b vb=%b de=%b rgb=%h hs=%b vs=%b",
               nm, cyc, g.x, g.y, g.act, g.vb, g.de, g.rgb, g.hs, g.vs,
               e.x, e.y, e.act, e.vb, e.de, e.rgb, e.hs, e.vs);
    end
  endtask

  task automatic check_int(string nm, int g, int e);
    vectors++;
    if (g != e) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got %0d want %0d", nm, cyc, g, e);
    end
  endtask

  task automatic cycle(bit r, logic [23:0] c);
    obs_t e [2];
    reset = r;
    color = c;
    for (int i = 0; i < 2; i++) begin
      int vlo;
      vlo = vvis[i] + vfr[i];
      e[i]     = stage0(r ? -1 : t + 1, i);
      e[i].de  = !r && prev[i].act;
      e[i].rgb = (!r && prev[i].act) ? c : 24'h0;
      e[i].hs  = (!r && prev[i].x >= 656 && prev[i].x < 752) ? 1'b0 : 1'b1;
      e[i].vs  = (!r && prev[i].y >= vlo && prev[i].y < vlo + vsy[i]) ? 1'b0 : 1'b1;
    end
    t = r ? -1 : t + 1;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      check(i == 0 ? "model_dflt" : "model_small", got[i], e[i]);
      prev[i] = e[i];
      if (r) last_vb[i] = -1;
      else if (got[i].vb) begin
        if (last_vb[i] >= 0)
          check_int(i == 0 ? "vblank_period_dflt" : "vblank_period_small",
                    cyc - last_vb[i], 800 * (vvis[i] + vfr[i] + vsy[i] + vbk[i]));
        last_vb[i] = cyc;
      end
    end
  endtask

  initial begin
    prev[0] = '0;
    prev[1] = '0;
    tab[0] = '{1'b1, 24'haaaaaa, mk(0, 0, 0, 0, 0, 24'h0, 1, 1)};
    tab[1] = '{1'b1, 24'haaaaaa, mk(0, 0, 0, 0, 0, 24'h0, 1, 1)};
    tab[2] = '{1'b1, 24'haaaaaa, mk(0, 0, 0, 0, 0, 24'h0, 1, 1)};
    tab[3] = '{1'b0, 24'h111111, mk(0, 0, 1, 0, 0, 24'h0, 1, 1)};
    tab[4] = '{1'b0, 24'h222222, mk(1, 0, 1, 0, 1, 24'h222222, 1, 1)};
    tab[5] = '{1'b0, 24'h333333, mk(2, 0, 1, 0, 1, 24'h333333, 1, 1)};
    for (int k = 0; k < 6; k++) begin
      cycle(tab[k].r, tab[k].c);
      check("table_dflt", got[0], tab[k].e);
      check("table_small", got[1], tab[k].e);
    end
    // Pipeline alignment, constant color, then random color across >2 short frames.
    for (int n = 0; n < 36000; n++)
      cycle(1'b0, n < 1600 ? {14'b0, x_d} : n < 4000 ? 24'h123456 : 24'($urandom));
    for (int k = 0; k < 800 && prev[0].x != 10'd300; k++)
      cycle(1'b0, 24'($urandom));
    cycle(1'b1, 24'hffffff);
    check_int("midreset_x", int'(x_d), 0);
    check_int("midreset_y", int'(y_d), 0);
    check_int("midreset_de", int'(de_d), 0);
    check_int("midreset_hsync", int'(hs_d), 1);
    for (int n = 0; n < 17000; n++)
      cycle(1'b0, 24'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vga_timing.md
# vga_timing

Generates 640x480@60 Hz raster timing from the 25 MHz pixel clock and is the consumer end of the x/y/color pixel interface. Game logic sees a registered pixel coordinate and returns a 24-bit color combinationally. The block re-registers that color together with pipeline-aligned sync and data-enable signals. These outputs feed the TMDS encoder/serializer stage. The block also emits a once-per-frame vertical-blank pulse, so game objects (paddles, ball) update on a frame basis instead of free-running counter bits.

## Interface

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, sync pulse polarity (0 = active-low)

Ports:
- clk_25mhz  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-high
- x  out  10  horizontal counter, stage 0, range 0..H_TOTAL-1
- y  out  10  vertical counter, stage 0, range 0..V_TOTAL-1
- active  out  1  stage 0; high when x<H_VISIBLE and y<V_VISIBLE
- vblank_start  out  1  stage 0; one-cycle pulse while (x,y)=(0,V_VISIBLE)
- color  in  24  RGB888 from the pixel generator; combinational function of x/y
- rgb  out  24  stage 1 registered pixel; forced 0 when de=0
- hsync  out  1  stage 1 horizontal sync
- vsync  out  1  stage 1 vertical sync
- de  out  1  stage 1 data enable (active delayed one cycle)

## Operation

- Derived totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). Both must be at most 1024 for the 10-bit counters.
- The x counter increments each cycle. At x=H_TOTAL-1 it wraps to 0 and y increments. At y=V_TOTAL-1 with x wrapping, y also wraps to 0. There is no enable input, so counting is unconditional.
- The stage 0 registers are x, y, active and vblank_start. Each is computed from the next-state counter values, so all four change together on the same edge.
- The sync windows are defined on stage 0 values:
  - hsync asserted when H_VISIBLE+H_FRONT ≤ x < H_VISIBLE+H_FRONT+H_SYNC, i.e. x in 656..751.
  - vsync asserted when V_VISIBLE+V_FRONT ≤ y < V_VISIBLE+V_FRONT+V_SYNC, i.e. y in 490..491.
  - vsync is line-based: it switches at x=0 boundaries only.
- Asserted means level SYNC_ACTIVE; deasserted means the inverse.
- Stage 1 captures four values each cycle:
  - de <= active
  - rgb <= active ? color : 0
  - hsync <= hsync window of the stage 0 x
  - vsync <= vsync window of the stage 0 y
- Reset values:
  - Stage 0: x=0, y=0, active=0, vblank_start=0.
  - Stage 1: rgb=0, de=0, hsync=vsync=~SYNC_ACTIVE (deasserted).
- Reset mid-frame behaves exactly like power-up: everything returns to the reset values on the next edge, with no partial-line completion. In the first cycle after reset deasserts, x=0, y=0 and active=1.
- color is ignored whenever active=0. X/undefined color during blanking must not propagate to rgb.

## Timing

- Latency: a color sampled in the cycle where x/y = (X,Y) appears on rgb, together with de/hsync/vsync for the same (X,Y), one cycle later.
- One frame is 800×525 = 420000 cycles, i.e. 59.52 Hz at 25 MHz.
- vblank_start is high for exactly one cycle per frame. It coincides with x=0, y=480.
- vblank_start gives game logic 45 lines (36000 cycles) before (0,0) recurs.

## Structure

- Shared package `video_pkg` holds:
  - the default 640x480 timing constants and derived H_TOTAL/V_TOTAL
  - the polarity constant
  - the 24-bit color typedef and a BLACK constant
- One natural sub-module, `video_axis_counter`, instantiated twice (horizontal and vertical):
  - inputs: clock, reset, tick-in, parameterized total / sync start / sync end / visible
  - outputs: count, wrap-out, visible flag, sync flag
  - the horizontal wrap-out drives the vertical tick-in.

## Test plan

- Reset held for 3 cycles, then released:
  - During reset: x=0, y=0, de=0, rgb=0, hsync=vsync=1.
  - First cycle after release: active=1 at (0,0).
  - Next edge: de=1.
- Full line, color=24'hFFFFFF:
  - de high for exactly 640 consecutive cycles.
  - hsync low for exactly 96 cycles, beginning one cycle after x=656.
  - Line period 800 cycles.
- Full frame:
  - vsync low for exactly 2×800 cycles, starting one cycle after (0,490).
  - vblank_start pulses once at (0,480).
  - Next pulse arrives 420000 cycles later.
  - y wraps 524→0 together with x 799→0.
- Color drive color=24'h123456 constantly:
  - rgb=24'h123456 only while de=1.
  - rgb=0 during all blanking cycles.
  - Driving color=X during blanking leaves rgb=0.
- Pipeline alignment, color={14'b0,x}:
  - At every de=1 cycle, rgb equals the previous cycle's x (0..639 in order per line).
- Reset asserted at (x=300,y=200) for 1 cycle:
  - Next cycle: x=0, y=0, de=0, hsync=1.
  - Following frame timing is identical to the power-up sequence.
